// File: rtl/data_memory.sv
// Word-addressed data memory. Every word powers up and resets to its own index.
// Reads are registered, and a read that coincides with a write returns the write data.
module data_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read_data_flag,
    input  logic                  write_data_flag,
    input  logic [DATA_WIDTH-1:0] data_to_write,
    input  logic [ADDR_WIDTH-1:0] address_of_data,
    output logic [DATA_WIDTH-1:0] data_read_out
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] word_arr [DEPTH];
    logic [DATA_WIDTH-1:0] read_reg = '0;
    logic [DATA_WIDTH-1:0] read_next;

    // Each word is its own register so that reset can restore the index pattern in one cycle.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [DATA_WIDTH-1:0] word_reg = DATA_WIDTH'(gi);

            always_ff @(posedge clk) begin
                if (reset) begin
                    word_reg <= DATA_WIDTH'(gi);
                end else if (write_data_flag && (address_of_data == ADDR_WIDTH'(gi))) begin
                    word_reg <= data_to_write;
                end
            end

            assign word_arr[gi] = word_reg;
        end
    endgenerate

    // The address is shared, so any simultaneous write targets the word being read.
    always_comb begin
        read_next = '0;
        if (read_data_flag) begin
            if (write_data_flag) begin
                read_next = data_to_write;
            end else begin
                read_next = word_arr[address_of_data];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_reg <= '0;
        end else begin
            read_reg <= read_next;
        end
    end

    assign data_read_out = read_reg;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: reset pattern, read sweeps, write-first behaviour,
// boundary addresses and reset priority over writes.
module tb_data_memory;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        read_data_flag = 1'b0;
    logic        write_data_flag = 1'b0;
    logic [31:0] data_to_write = '0;
    logic [7:0]  address_of_data = '0;
    logic [31:0] data_read_out;

    int total = 0;
    int bad = 0;

    data_memory dut (
        .clk             (clk),
        .reset           (reset),
        .read_data_flag  (read_data_flag),
        .write_data_flag (write_data_flag),
        .data_to_write   (data_to_write),
        .address_of_data (address_of_data),
        .data_read_out   (data_read_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic rd, input logic wr,
                         input logic [7:0] addr, input logic [31:0] data);
        reset = rst;
        read_data_flag = rd;
        write_data_flag = wr;
        address_of_data = addr;
        data_to_write = data;
    endtask

    initial begin
        logic all_ok;
        #1;
        check("powerup_out", data_read_out, 32'h0);

        // Pattern must be present before any reset.
        drive(1'b0, 1'b1, 1'b0, 8'd10, 32'h0);
        tick();
        check("powerup_rd10", data_read_out, 32'd10);

        drive(1'b1, 1'b1, 1'b0, 8'd10, 32'h0);
        tick();
        check("reset_out", data_read_out, 32'h0);

        drive(1'b0, 1'b0, 1'b0, 8'd20, 32'h0);
        tick();
        check("rdoff_1", data_read_out, 32'h0);
        tick();
        check("rdoff_2", data_read_out, 32'h0);

        // Read-only sweep of the whole address range.
        all_ok = 1'b1;
        for (int a = 0; a < 256; a++) begin
            drive(1'b0, 1'b1, 1'b0, 8'(a), 32'hFFFF_FFFF);
            tick();
            check($sformatf("sweep_rd_%0d", a), data_read_out, 32'(a));
        end

        // Output holds between edges even when inputs move.
        drive(1'b0, 1'b1, 1'b0, 8'd77, 32'h0);
        #3;
        check("hold_between_edges", data_read_out, 32'd255);

        // Write disabled leaves memory untouched.
        drive(1'b0, 1'b0, 1'b0, 8'd4, 32'hCAFE_F00D);
        tick();
        drive(1'b0, 1'b1, 1'b0, 8'd4, 32'h0);
        tick();
        check("nowrite_rd4", data_read_out, 32'd4);

        // Write-first sweep.
        for (int a = 0; a < 256; a++) begin
            drive(1'b0, 1'b1, 1'b1, 8'(a), 32'd5);
            tick();
            check($sformatf("wf_%0d", a), data_read_out, 32'd5);
        end
        for (int a = 0; a < 256; a++) begin
            drive(1'b0, 1'b1, 1'b0, 8'(a), 32'h0);
            tick();
            check($sformatf("after_wf_%0d", a), data_read_out, 32'd5);
        end

        // Reset restores the pattern; output is zero during reset even with read enabled.
        drive(1'b1, 1'b1, 1'b0, 8'd7, 32'h0);
        tick();
        check("reset2_out", data_read_out, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 8'd7, 32'h0);
        tick();
        check("reset2_rd7", data_read_out, 32'd7);
        drive(1'b0, 1'b1, 1'b0, 8'd200, 32'h0);
        tick();
        check("reset2_rd200", data_read_out, 32'd200);

        // Boundary addresses.
        drive(1'b0, 1'b0, 1'b1, 8'hFF, 32'hDEAD_BEEF);
        tick();
        check("wr_only_out", data_read_out, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 8'h00, 32'h1234_5678);
        tick();
        drive(1'b0, 1'b1, 1'b0, 8'hFF, 32'h0);
        tick();
        check("rd_ff", data_read_out, 32'hDEAD_BEEF);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
        tick();
        check("rd_00", data_read_out, 32'h1234_5678);
        drive(1'b0, 1'b1, 1'b0, 8'h01, 32'h0);
        tick();
        check("rd_01", data_read_out, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 8'h01, 32'h0);
        tick();
        check("rd_off_after_rd", data_read_out, 32'h0);

        // Write during reset is discarded.
        drive(1'b1, 1'b1, 1'b1, 8'd3, 32'h0000_AAAA);
        tick();
        check("rst_wr_out", data_read_out, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 8'd3, 32'h0);
        tick();
        check("rst_wr_rd3", data_read_out, 32'd3);
        drive(1'b0, 1'b1, 1'b0, 8'hFF, 32'h0);
        tick();
        check("rst_restores_ff", data_read_out, 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits; only the default is required to work.
REQ-002 Parameter ADDR_WIDTH, default 8, address width; depth = 2**ADDR_WIDTH = 256 words.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 read_data_flag  input  1  read enable.
REQ-006 write_data_flag  input  1  write enable.
REQ-007 data_to_write  input  DATA_WIDTH  write data.
REQ-008 address_of_data  input  ADDR_WIDTH  word address shared by read and write.
REQ-009 data_read_out  output  DATA_WIDTH  registered read data.

Function
REQ-010 Storage SHALL be 256 words x 32 bits, word-addressed; no byte enables, no address translation.
REQ-011 Memory contents SHALL be initialised so that word[i] = i (zero-extended to 32 bits) for i = 0..255, at time zero and on every reset.
REQ-012 Write: on a rising clk with reset=0 and write_data_flag=1, word[address_of_data] SHALL be loaded with data_to_write.
REQ-013 Write with write_data_flag=0 SHALL leave memory unchanged.
REQ-014 Read: on a rising clk with reset=0 and read_data_flag=1, data_read_out SHALL be loaded with word[address_of_data]; read latency = 1 clock.
REQ-015 Read with read_data_flag=0 SHALL load data_read_out with 0 on that rising edge.
REQ-016 Simultaneous read and write to the same address SHALL be write-first: data_read_out gets data_to_write in the same edge.
REQ-017 data_read_out SHALL hold its value between rising edges; no combinational path from inputs to data_read_out.
REQ-018 All 8 address bits SHALL be decoded; addresses 0 and 255 are valid and there is no wrap-around or out-of-range case.
REQ-019 Inputs are sampled only on rising clk; glitches between edges SHALL have no effect.

Reset
REQ-020 When reset=1 on a rising clk, data_read_out SHALL become 0 and all words SHALL be restored to word[i] = i.
REQ-021 Reset SHALL take priority over simultaneous read and write; a write asserted in the reset cycle SHALL be discarded.
REQ-022 Normal operation SHALL resume on the first rising clk with reset=0.
REQ-023 Before the first reset, data_read_out SHALL power up at 0 and memory SHALL hold the REQ-011 pattern.

Verification
REQ-024 Reset, then read_data_flag=0 for 2 cycles -> data_read_out = 0.
REQ-025 read_data_flag=1, write_data_flag=0, sweep address 0..255 one per cycle -> data_read_out = address one cycle later, for all 256 addresses.
REQ-026 read_data_flag=1, write_data_flag=1, data_to_write=5, sweep address 0..255 -> data_read_out = 5 each cycle (write-first); a later read-only sweep returns 5 at every address.
REQ-027 Write 0xDEADBEEF to address 0xFF, then 0x12345678 to address 0x00, then read both -> 0xDEADBEEF and 0x12345678, and address 0x01 still returns 1.
REQ-028 After REQ-026, assert reset for 1 cycle, then read addresses 7 and 200 -> 7 and 200, and data_read_out = 0 during reset.
REQ-029 Assert write_data_flag=1 with reset=1 at address 3, data 0xAAAA; then read address 3 -> 3, with the write discarded.
